gf180mcu_fd_sc_mcu9t5v0__nand3_capture_bank: RTL and testbench
==============================================================

// Module: gf180mcu_fd_sc_mcu9t5v0__nand3_capture_bank
// PURPOSE
//   Downstream capture stage for the nand3 cell family: a WIDTH-bit bank of scan
//   flops with integrated clock gating. Each bit registers ZN = ~(A1 & A2 & A3).
//   Used as a functional model for the decode-and-register macros in the 9-track
//   5V library. Also used as the cell-level harness for nand3 timing/functional
//   sign-off.
// PARAMETERS
//   WIDTH   4   number of bits in the bank; legal range 1..32
// PORTS
//   CLK  input   1      clock; rising-edge triggered
//   RN   input   1      reset; asynchronous, active-low
//   A1   input   WIDTH  nand3 input 1, per bit
//   A2   input   WIDTH  nand3 input 2, per bit
//   A3   input   WIDTH  nand3 input 3, per bit
//   E    input   1      functional capture enable
//   SE   input   1      scan enable; overrides E
//   SI   input   1      scan-in; enters bit 0
//   Q    output  WIDTH  registered outputs
//   SO   output  1      scan-out; always equals Q[WIDTH-1]
// BEHAVIOUR
//   - One clock (CLK). Reset RN is asynchronous and active-low.
//   - Reset: RN=0 forces Q=0 and SO=0 immediately, without waiting for a CLK edge.
//     - Q holds 0 while RN=0.
//     - On RN release, the first capture happens at the first CLK rise seen after
//       RN is 1.
//     - Reset asserted mid-shift or mid-capture wins. No partial update is allowed.
//   - Clock gate: gclk_en = E | SE.
//     - gclk_en is captured by a latch that is transparent while CLK=0 and holds
//       while CLK=1.
//     - Internal gated clock = CLK & latched_en. It must be glitch-free.
//     - E or SE toggling while CLK=1 has no effect on the current edge.
//     - The gating latch is not reset. It re-samples on the first CLK-low phase.
//   - On each gated rising edge, in priority order:
//     1. SE=1 (shift): Q <= {Q[WIDTH-2:0], SI}. For WIDTH=1: Q <= SI.
//     2. SE=0, E=1 (capture): Q[i] <= ~(A1[i] & A2[i] & A3[i]) for each bit i.
//   - Without a gated edge (E=0 and SE=0 latched), Q holds.
//   - Latency: one CLK edge from input to Q. SO follows Q[WIDTH-1] combinationally.
//   - X handling:
//     - An X/Z on an input of bit i propagates to Q[i] only if ZN[i] is unresolved.
//     - Any 0 on A1/A2/A3 forces a 1 regardless of the other inputs.
//     - An X on the latched enable makes all Q bits X on the edge.
//     - An X on RN makes Q X.
// STRUCTURE
//   - No shared package. WIDTH is the only configuration.
//   - There are no typedefs. Nothing is shared with other cells beyond this naming.
//   - One sub-module, gf180mcu_fd_sc_mcu9t5v0__nand3_sdff_bit:
//     - Holds the nand3 ZN, the SE/SI mux, and the async-reset flop for one bit.
//     - Instantiated WIDTH times in a generate loop.
//     - Bit i takes the scan input from bit i-1, or from SI for bit 0.
//   - The clock-gate latch and AND sit once in the top level, shared by all bits.
// TESTING
//   (WIDTH=4 unless stated.)
//   1. Reset:
//      - Drive RN=0 between clock edges -> Q=4'b0000 and SO=0 immediately.
//      - Release RN, no clock edge -> Q stays 0.
//   2. Capture:
//      - E=1, SE=0, A1=4'b1111, A2=4'b1011, A3=4'b1110, one edge -> Q=4'b0101.
//      - E=0, change A*, one edge -> Q holds 4'b0101.
//   3. Shift:
//      - From Q=4'b0000, SE=1, SI=1,0,1,1 over 4 edges -> Q=4'b1011.
//      - SO sequence is 0,0,0,1.
//   4. Priority:
//      - SE=1 and E=1 together, SI=0, Q=4'b0101 -> Q=4'b1010.
//      - The nand3 result is ignored.
//   5. Gating:
//      - E rises while CLK=1 -> no update on that edge.
//      - The next edge captures.
//      - E falls while CLK=1 after the latch has sampled 1 -> that edge still captures.
//   6. Reset mid-operation:
//      - RN pulsed low during the CLK-high phase after Q=4'b1011 -> Q=0 at once.
//      - Next edge with RN=1, E=1, all A*=1 -> Q=4'b0000.
//      - Then A1=0 and one edge -> Q=4'b1111.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nand3_sdff_bit.sv
// One bit of the nand3 capture bank.
// The nand3 decode feeds a scan mux, and the mux feeds a flop with an
// asynchronous active-low reset. The clock arriving here is already gated
// by the bank, so every rising edge on clk is a real update.
module gf180mcu_fd_sc_mcu9t5v0__nand3_sdff_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic se,
    input  logic si,
    output logic q
);

    logic zn;

    // Any 0 on an input forces zn to 1, even when another input is X/Z.
    assign zn = ~(a1 & a2 & a3);

    // Scan shift has priority over functional capture. Reset wins over both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (se) begin
            q <= si;
        end else begin
            q <= zn;
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nand3_capture_bank.sv
// WIDTH-bit bank of nand3 scan flops behind one shared clock gate.
// The enable latch is transparent while CLK is low. This stops E or SE
// changing during the high phase from chopping the gated clock. The latch
// has no reset and picks up a clean value on the first low phase of CLK.
module gf180mcu_fd_sc_mcu9t5v0__nand3_capture_bank #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    input  logic [WIDTH-1:0] A3,
    input  logic             E,
    input  logic             SE,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             SO
);

    logic gclk_en;
    logic en_lat;
    logic gclk;

    assign gclk_en = E | SE;

    // Enable latch: follows gclk_en while CLK is low and holds while CLK is high.
    always_latch begin
        if (!CLK) begin
            en_lat <= gclk_en;
        end
    end

    assign gclk = CLK & en_lat;

    // Bit 0 shifts in SI. Every other bit shifts in its lower neighbour.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic scan_in;

        if (i == 0) begin : g_head
            assign scan_in = SI;
        end else begin : g_tail
            assign scan_in = Q[i-1];
        end

        gf180mcu_fd_sc_mcu9t5v0__nand3_sdff_bit u_bit (
            .clk   (gclk),
            .rst_n (RN),
            .a1    (A1[i]),
            .a2    (A2[i]),
            .a3    (A3[i]),
            .se    (SE),
            .si    (scan_in),
            .q     (Q[i])
        );
    end

    assign SO = Q[WIDTH-1];

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__nand3_capture_bank.sv
// Directed bench for the nand3 capture bank at WIDTH=4.
module tb_gf180mcu_fd_sc_mcu9t5v0__nand3_capture_bank;

    localparam int WIDTH = 4;

    logic             CLK;
    logic             RN;
    logic [WIDTH-1:0] A1;
    logic [WIDTH-1:0] A2;
    logic [WIDTH-1:0] A3;
    logic             E;
    logic             SE;
    logic             SI;
    logic [WIDTH-1:0] Q;
    logic             SO;

    int n_cmp;
    int n_mis;

    gf180mcu_fd_sc_mcu9t5v0__nand3_capture_bank #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RN  (RN),
        .A1  (A1),
        .A2  (A2),
        .A3  (A3),
        .E   (E),
        .SE  (SE),
        .SI  (SI),
        .Q   (Q),
        .SO  (SO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got still running, required finished");
        $fatal(1);
    end

    task automatic test_reset;
        repeat (2) @(negedge CLK);
        #2;
        RN = 1'b0;
        #1;
        n_cmp++;
        if (Q !== 4'b0000) begin
            n_mis++;
            $display("FAIL reset_async_q: got %b, required 0000", Q);
        end
        n_cmp++;
        if (SO !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_async_so: got %b, required 0", SO);
        end
        E  = 1'b1;
        A1 = 4'b0000;
        @(posedge CLK);
        #1;
        n_cmp++;
        if (Q !== 4'b0000) begin
            n_mis++;
            $display("FAIL reset_hold_on_edge: got %b, required 0000", Q);
        end
        @(negedge CLK);
        E  = 1'b0;
        RN = 1'b1;
        #1;
        n_cmp++;
        if (Q !== 4'b0000) begin
            n_mis++;
            $display("FAIL reset_release_no_edge: got %b, required 0000", Q);
        end
        @(posedge CLK);
        #1;
        n_cmp++;
        if (Q !== 4'b0000) begin
            n_mis++;
            $display("FAIL reset_release_gated_off: got %b, required 0000", Q);
        end
    endtask

    task automatic test_capture;
        @(negedge CLK);
        E  = 1'b1;
        SE = 1'b0;
        A1 = 4'b1111;
        A2 = 4'b1011;
        A3 = 4'b1110;
        @(posedge CLK);
        #1;
        n_cmp++;
        if (Q !== 4'b0101) begin
            n_mis++;
            $display("FAIL capture_nand3: got %b, required 0101", Q);
        end
        n_cmp++;
        if (SO !== 1'b0) begin
            n_mis++;
            $display("FAIL capture_so: got %b, required 0", SO);
        end
        @(negedge CLK);
        E  = 1'b0;
        A1 = 4'b0000;
        @(posedge CLK);
        #1;
        n_cmp++;
        if (Q !== 4'b0101) begin
            n_mis++;
            $display("FAIL capture_hold_e0: got %b, required 0101", Q);
        end
    endtask

    task automatic test_priority;
        @(negedge CLK);
        E  = 1'b1;
        SE = 1'b1;
        SI = 1'b0;
        A1 = 4'b0000;
        A2 = 4'b0000;
        A3 = 4'b0000;
        @(posedge CLK);
        #1;
        n_cmp++;
        if (Q !== 4'b1010) begin
            n_mis++;
            $display("FAIL priority_shift_over_capture: got %b, required 1010", Q);
        end
        n_cmp++;
        if (SO !== 1'b1) begin
            n_mis++;
            $display("FAIL priority_so: got %b, required 1", SO);
        end
    endtask

    task automatic test_gating;
        @(negedge CLK);
        E  = 1'b0;
        SE = 1'b0;
        A1 = 4'b1111;
        A2 = 4'b1111;
        A3 = 4'b0011;
        @(posedge CLK);
        #2;
        E = 1'b1;
        #1;
        n_cmp++;
        if (Q !== 4'b1010) begin
            n_mis++;
            $display("FAIL gating_e_rise_high: got %b, required 1010", Q);
        end
        @(posedge CLK);
        #1;
        n_cmp++;
        if (Q !== 4'b1100) begin
            n_mis++;
            $display("FAIL gating_next_edge_captures: got %b, required 1100", Q);
        end
        @(negedge CLK);
        A3 = 4'b1111;
        @(posedge CLK);
        #1;
        E = 1'b0;
        #1;
        n_cmp++;
        if (Q !== 4'b0000) begin
            n_mis++;
            $display("FAIL gating_e_fall_high_captures: got %b, required 0000", Q);
        end
        @(negedge CLK);
        A3 = 4'b0000;
        @(posedge CLK);
        #1;
        n_cmp++;
        if (Q !== 4'b0000) begin
            n_mis++;
            $display("FAIL gating_hold_after_fall: got %b, required 0000", Q);
        end
    endtask

    task automatic test_shift;
        logic             si_seq [4];
        logic [WIDTH-1:0] q_exp  [4];
        logic             so_exp [4];
        si_seq = '{1'b1, 1'b0, 1'b1, 1'b1};
        q_exp  = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        so_exp = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            E  = 1'b0;
            SE = 1'b1;
            SI = si_seq[k];
            @(posedge CLK);
            #1;
            n_cmp++;
            if (Q !== q_exp[k]) begin
                n_mis++;
                $display("FAIL shift_q[%0d]: got %b, required %b", k, Q, q_exp[k]);
            end
            n_cmp++;
            if (SO !== so_exp[k]) begin
                n_mis++;
                $display("FAIL shift_so[%0d]: got %b, required %b", k, SO, so_exp[k]);
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge CLK);
        SE = 1'b0;
        E  = 1'b0;
        @(posedge CLK);
        #1;
        RN = 1'b0;
        #1;
        n_cmp++;
        if (Q !== 4'b0000) begin
            n_mis++;
            $display("FAIL reset_mid_q: got %b, required 0000", Q);
        end
        n_cmp++;
        if (SO !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_mid_so: got %b, required 0", SO);
        end
        #1;
        RN = 1'b1;
        @(negedge CLK);
        E  = 1'b1;
        A1 = 4'b1111;
        A2 = 4'b1111;
        A3 = 4'b1111;
        @(posedge CLK);
        #1;
        n_cmp++;
        if (Q !== 4'b0000) begin
            n_mis++;
            $display("FAIL reset_mid_all_ones: got %b, required 0000", Q);
        end
        @(negedge CLK);
        A1 = 4'b0000;
        @(posedge CLK);
        #1;
        n_cmp++;
        if (Q !== 4'b1111) begin
            n_mis++;
            $display("FAIL reset_mid_a1_zero: got %b, required 1111", Q);
        end
        n_cmp++;
        if (SO !== 1'b1) begin
            n_mis++;
            $display("FAIL reset_mid_so_high: got %b, required 1", SO);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        RN = 1'b1;
        A1 = '0;
        A2 = '0;
        A3 = '0;
        E  = 1'b0;
        SE = 1'b0;
        SI = 1'b0;
        test_reset();
        test_capture();
        test_priority();
        test_gating();
        test_shift();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
